// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
//
// Shared definitions for the arithmetic stages.
//   state_t        : sequencing states of the shift-and-add multiplier
//   DEFAULT_WIDTH  : default operand width for the multiplier
//   cnt_width()    : number of bits needed for the step counter
// ---------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // The counter runs 0..width-1, so clog2(width) bits always suffice.
    // Clamp to one bit so the degenerate width still yields a legal vector.
    function automatic int cnt_width(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mult_add_step.sv
// ---------------------------------------------------------------------------
// mult_add_step
//
// Purely combinational WIDTH-bit adder that exposes its carry-out.
// The multiplier uses one of these per partial-product step.
//
// Ports:
//   a         in  WIDTH  first addend (running accumulator)
//   b         in  WIDTH  second addend (multiplicand or zero)
//   sum       out WIDTH  low WIDTH bits of a + b
//   carry_out out 1      bit WIDTH of a + b
// ---------------------------------------------------------------------------
module mult_add_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Zero-extend both addends so the carry lands in the extra bit.
    always_comb begin
        {carry_out, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Multi-cycle unsigned multiplier. One partial product is folded in per
// clock. A single mult_add_step adder is shared by all steps. A result
// appears WIDTH+1 cycles after an accepted start.
//
// Ports:
//   clk      in  1        rising-edge clock
//   rst      in  1        synchronous active-high reset, beats start
//   start    in  1        begin a multiply (accepted in IDLE or DONE)
//   a        in  WIDTH    multiplicand, captured on an accepted start
//   b        in  WIDTH    multiplier, captured on an accepted start
//   busy     out 1        high while the steps are running
//   done     out 1        one-cycle pulse, product is valid
//   product  out 2*WIDTH  registered result, held until next completion
// ---------------------------------------------------------------------------
module shift_add_multiplier
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [WIDTH-1:0]   mq_q,      mq_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [WIDTH-1:0]   add_operand;
    logic [WIDTH-1:0]   step_sum;
    logic               step_carry;

    // Adding zero when the current multiplier bit is clear gives {0,acc}
    // without a separate bypass path.
    assign add_operand = mq_q[0] ? mcand_q : '0;

    mult_add_step #(
        .WIDTH (WIDTH)
    ) u_add_step (
        .a         (acc_q),
        .b         (add_operand),
        .sum       (step_sum),
        .carry_out (step_carry)
    );

    // Next-state logic. In RUN, {carry,sum,mq} shifts right one place into
    // {acc,mq}, so the carry becomes the accumulator MSB and is never lost.
    // The product is captured from the same next values on the last step.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = '0;
                    mq_d    = b;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = {step_carry, step_sum[WIDTH-1:1]};
                mq_d  = {step_sum[0], mq_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    product_d = {acc_d, mq_d};
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // All state, including the status outputs, is registered here so busy
    // and done are glitch-free and line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Drives a WIDTH=4 and a WIDTH=8 multiplier from one clock. Expected
// products are queued when a start is driven and popped whenever done
// pulses. Cycle-by-cycle busy/done timing is checked alongside.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_s = 1'b0;
    logic [3:0]  a_s = '0;
    logic [3:0]  b_s = '0;
    logic        busy_s;
    logic        done_s;
    logic [7:0]  product_s;

    logic        start_w = 1'b0;
    logic [7:0]  a_w = '0;
    logic [7:0]  b_w = '0;
    logic        busy_w;
    logic        done_w;
    logic [15:0] product_w;

    int compare_count  = 0;
    int mismatch_count = 0;

    logic [15:0] sb_small[$];
    logic [15:0] sb_wide[$];

    shift_add_multiplier #(.WIDTH(4)) dut_small (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .a       (a_s),
        .b       (b_s),
        .busy    (busy_s),
        .done    (done_s),
        .product (product_s)
    );

    shift_add_multiplier #(.WIDTH(8)) dut_wide (
        .clk     (clk),
        .rst     (rst),
        .start   (start_w),
        .a       (a_w),
        .b       (b_w),
        .busy    (busy_w),
        .done    (done_w),
        .product (product_w)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic busy_of(input int width);
        return (width == 8) ? busy_w : busy_s;
    endfunction

    function automatic logic done_of(input int width);
        return (width == 8) ? done_w : done_s;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued product.
    always @(negedge clk) begin
        if (done_s === 1'b1) begin
            if (sb_small.size() == 0) begin
                checkOutput("unexpected done W4", 32'(done_s), 32'd0);
            end else begin
                checkOutput("product W4", 32'(product_s), 32'(sb_small.pop_front()));
            end
        end
        if (done_w === 1'b1) begin
            if (sb_wide.size() == 0) begin
                checkOutput("unexpected done W8", 32'(done_w), 32'd0);
            end else begin
                checkOutput("product W8", 32'(product_w), 32'(sb_wide.pop_front()));
            end
        end
    end

    // Drive a one-cycle start; returns at the negedge of cycle 1.
    task automatic applyStimulus(input int width, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if (width == 8) begin
            a_w = a;
            b_w = b;
            start_w = 1'b1;
            sb_wide.push_back(16'(a) * 16'(b));
        end else begin
            a_s = a[3:0];
            b_s = b[3:0];
            start_s = 1'b1;
            sb_small.push_back(16'(a[3:0]) * 16'(b[3:0]));
        end
        @(negedge clk);
        start_s = 1'b0;
        start_w = 1'b0;
    endtask

    // Called at the negedge of cycle from_cycle; checks busy through cycle
    // width and the done pulse in cycle width+1.
    task automatic checkRun(input string tag, input int width, input int from_cycle);
        for (int c = from_cycle; c <= width; c++) begin
            if (c > from_cycle) @(negedge clk);
            checkOutput({tag, " busy"}, 32'(busy_of(width)), 32'd1);
            checkOutput({tag, " early done"}, 32'(done_of(width)), 32'd0);
        end
        @(negedge clk);
        checkOutput({tag, " done"}, 32'(done_of(width)), 32'd1);
        checkOutput({tag, " busy at done"}, 32'(busy_of(width)), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset busy W4", 32'(busy_s), 32'd0);
        checkOutput("reset done W4", 32'(done_s), 32'd0);
        checkOutput("reset product W4", 32'(product_s), 32'd0);
        checkOutput("reset busy W8", 32'(busy_w), 32'd0);
        checkOutput("reset product W8", 32'(product_w), 32'd0);
        rst = 1'b0;

        // Zero operands still take every step.
        applyStimulus(4, 8'd0, 8'd0);
        checkRun("zero", 4, 1);

        // All-ones exercises the carry into the accumulator MSB.
        applyStimulus(4, 8'd15, 8'd15);
        checkRun("max W4", 4, 1);
        checkOutput("max W4 value", 32'(product_s), 32'hE1);

        // A start during RUN must be ignored.
        applyStimulus(4, 8'd13, 8'd11);
        checkOutput("ignore busy c1", 32'(busy_s), 32'd1);
        a_s = 4'd3;
        b_s = 4'd5;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        checkRun("ignore", 4, 2);
        checkOutput("ignore value", 32'(product_s), 32'h8F);
        @(negedge clk);
        checkOutput("ignore no relaunch", 32'(busy_s), 32'd0);
        checkOutput("ignore no second done", 32'(done_s), 32'd0);

        // Back-to-back: start held high, new operands given in DONE.
        @(negedge clk);
        a_s = 4'd2;
        b_s = 4'd7;
        start_s = 1'b1;
        sb_small.push_back(16'd14);
        @(negedge clk);
        checkRun("b2b first", 4, 1);
        checkOutput("b2b first value", 32'(product_s), 32'h0E);
        a_s = 4'd6;
        b_s = 4'd9;
        sb_small.push_back(16'd54);
        @(negedge clk);
        start_s = 1'b0;
        checkOutput("b2b held c1", 32'(product_s), 32'h0E);
        checkRun("b2b second", 4, 1);
        checkOutput("b2b second value", 32'(product_s), 32'h36);

        // Reset in cycle 2 aborts the operation with no done pulse.
        applyStimulus(4, 8'd9, 8'd9);
        @(negedge clk);
        rst = 1'b1;
        sb_small.delete();
        @(negedge clk);
        checkOutput("abort busy", 32'(busy_s), 32'd0);
        checkOutput("abort done", 32'(done_s), 32'd0);
        checkOutput("abort product", 32'(product_s), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("abort no done", 32'(done_s), 32'd0);
        end

        // Wide instance: maximum operands then a random sweep.
        applyStimulus(8, 8'd255, 8'd255);
        checkRun("max W8", 8, 1);
        checkOutput("max W8 value", 32'(product_w), 32'hFE01);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            checkRun("random W8", 8, 1);
        end

        @(negedge clk);
        checkOutput("pending W4", 32'(sb_small.size()), 32'd0);
        checkOutput("pending W8", 32'(sb_wide.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
